// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset instruction and default reset PC.
package core_pkg;

    localparam int CORE_XLEN = 32;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_REQ  = 2'd0;
    localparam fetch_state_t S_WAIT = 2'd1;
    localparam fetch_state_t S_EXEC = 2'd2;
    localparam fetch_state_t S_HALT = 2'd3;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: sequential pc+4 or jump target with bit 0 forced low, plus alignment flag.
module next_pc_mux
    import core_pkg::*;
#(
    parameter int W = CORE_XLEN
) (
    input  logic         pcsel_i,
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] alu_target_i,
    output logic [W-1:0] pc_plus4_o,
    output logic [W-1:0] next_pc_o,
    output logic         misaligned_o
);

    assign pc_plus4_o = pc_i + W'(4);

    // jalr semantics: the target LSB is always discarded
    assign next_pc_o    = pcsel_i ? (alu_target_i & ~W'(1)) : pc_plus4_o;
    assign misaligned_o = next_pc_o[1];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the architectural PC, issues one fetch per instruction and
// holds the returned word for decode until commit selects the next PC.
//
// state  | meaning
// S_REQ  | request pending on imem, address = pc
// S_WAIT | request accepted, waiting for response word
// S_EXEC | inst valid and held, waiting for commit
// S_HALT | misaligned target taken, frozen until reset
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            commit,
    input  logic            PCSel,
    input  logic [XLEN-1:0] alu_target,
    output logic            misalign
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            req_valid_q, req_valid_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    next_pc_mux #(.W(XLEN)) u_next_pc_mux (
        .pcsel_i      (PCSel),
        .pc_i         (pc_q),
        .alu_target_i (alu_target),
        .pc_plus4_o   (pc_plus4),
        .next_pc_o    (next_pc),
        .misaligned_o (next_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;
        case (state_q)
            S_REQ: begin
                if (req_valid_q && imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d       = imem_rsp_data;
                    inst_valid_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    inst_valid_d = 1'b0;
                    if (next_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            default: ;
        endcase
        // registered request: asserted for every cycle the FSM will sit in S_REQ
        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= XLEN'(RESET_PC);
            inst_q       <= XLEN'(NOP_INST);
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            req_valid_q  <= req_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = inst_valid_q;
    assign pc             = pc_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/commit traffic compared against a PC-sequence reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit = 1'b0;
    logic        PCSel = 1'b0;
    logic [31:0] alu_target = 32'h0;
    logic        misalign;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;

    instr_fetch_unit #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .commit         (commit),
        .PCSel          (PCSel),
        .alu_target     (alu_target),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: architectural next-PC from the ISA rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input bit sel, input logic [31:0] tgt);
        longint unsigned s;
        if (sel) return tgt - (tgt % 32'd2);
        s = (longint'(cur) + 4) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] nxt);
        return (nxt % 32'd4) != 0;
    endfunction

    // Memory model: waits for a request, stalls ready, then answers after lat cycles.
    // ok drops if the request never appears, moves while stalled, or the FSM misbehaves.
    task automatic do_fetch(input int stall, input int lat, input logic [31:0] data,
                            output logic [31:0] addr, output bit ok);
        int n = 0;
        ok   = 1'b1;
        addr = 32'hx;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req_valid) begin
            ok = 1'b0;
            return;
        end
        addr = imem_req_addr;
        for (int i = 0; i < stall; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            @(negedge clk);
            if (!imem_req_valid || imem_req_addr !== addr || inst_valid) ok = 1'b0;
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        if (imem_req_valid || inst_valid) ok = 1'b0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if (imem_req_valid || inst_valid) ok = 1'b0;
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
    endtask

    task automatic do_commit(input bit sel, input logic [31:0] tgt);
        commit     = 1'b1;
        PCSel      = sel;
        alu_target = tgt;
        @(negedge clk);
        commit     = 1'b0;
        PCSel      = $urandom_range(0, 1);
        alu_target = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (pc !== RST_PC) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, RST_PC); end
        tests++; if (inst !== NOP) begin fails++; $display("FAIL reset_inst got %h exp %h", inst, NOP); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
        tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b exp 0", misalign); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
        tests++; if (imem_req_addr !== RST_PC) begin fails++; $display("FAIL first_req_addr got %h exp %h", imem_req_addr, RST_PC); end
        exp_pc = RST_PC;
    endtask

    task automatic test_first_fetch();
        logic [31:0] a;
        bit ok;
        do_fetch(0, 1, 32'h0050_0093, a, ok);
        tests++; if (!ok) begin fails++; $display("FAIL first_fetch_handshake ok=%b exp 1", ok); end
        tests++; if (a !== 32'h0) begin fails++; $display("FAIL first_fetch_addr got %h exp 00000000", a); end
        tests++; if (inst !== 32'h0050_0093) begin fails++; $display("FAIL first_fetch_inst got %h exp 00500093", inst); end
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL first_fetch_valid got %b exp 1", inst_valid); end
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL first_fetch_pc got %h exp 0", pc); end
        tests++; if (pc_plus4 !== 32'h4) begin fails++; $display("FAIL first_fetch_pc_plus4 got %h exp 4", pc_plus4); end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        bit ok;
        do_commit(1'b0, $urandom);
        exp_pc = ref_next(exp_pc, 1'b0, 32'h0);
        do_fetch(3, 1, 32'hDEAD_0013, a, ok);
        tests++; if (!ok) begin fails++; $display("FAIL stall_hold ok=%b exp 1", ok); end
        tests++; if (a !== exp_pc) begin fails++; $display("FAIL stall_addr got %h exp %h", a, exp_pc); end
        tests++; if (inst !== 32'hDEAD_0013) begin fails++; $display("FAIL stall_inst got %h exp dead0013", inst); end
    endtask

    task automatic test_jumps();
        logic [31:0] a;
        bit ok;
        do_commit(1'b1, 32'h10);
        exp_pc = ref_next(exp_pc, 1'b1, 32'h10);
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL commit_drops_valid got %b exp 0", inst_valid); end
        do_fetch(0, 2, 32'h1111_1111, a, ok);
        tests++; if (a !== 32'h10 || !ok) begin fails++; $display("FAIL jump_0x10 got %h ok=%b exp 00000010", a, ok); end
        do_commit(1'b0, 32'hFFFF_0000);
        exp_pc = ref_next(exp_pc, 1'b0, 32'h0);
        do_fetch(1, 1, 32'h2222_2222, a, ok);
        tests++; if (a !== 32'h14 || !ok) begin fails++; $display("FAIL seq_0x14 got %h ok=%b exp 00000014", a, ok); end
        do_commit(1'b1, 32'h0000_0101);
        exp_pc = ref_next(exp_pc, 1'b1, 32'h0000_0101);
        do_fetch(0, 1, 32'h3333_3333, a, ok);
        tests++; if (a !== 32'h100 || !ok) begin fails++; $display("FAIL jalr_lsb_clear got %h ok=%b exp 00000100", a, ok); end
        tests++; if (pc !== 32'h100) begin fails++; $display("FAIL jalr_pc got %h exp 00000100", pc); end
        tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL jalr_misalign got %b exp 0", misalign); end
    endtask

    task automatic test_rsp_ignored();
        logic [31:0] held;
        held = inst;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~held;
        repeat (2) @(negedge clk);
        imem_rsp_valid = 1'b0;
        tests++; if (inst !== held || inst_valid !== 1'b1) begin fails++; $display("FAIL exec_rsp_ignored got %h/%b exp %h/1", inst, inst_valid, held); end
        tests++; if (pc !== exp_pc || imem_req_valid !== 1'b0) begin fails++; $display("FAIL exec_hold got pc=%h req=%b exp pc=%h req=0", pc, imem_req_valid, exp_pc); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, tgt;
        bit ok, sel;
        for (int i = 0; i < 30; i++) begin
            sel = 1'($urandom_range(0, 1));
            tgt = $urandom & 32'hFFFF_FFFD;
            do_commit(sel, tgt);
            exp_pc = ref_next(exp_pc, sel, tgt);
            d = $urandom;
            do_fetch($urandom_range(0, 3), $urandom_range(1, 4), d, a, ok);
            tests++;
            if (!ok || a !== exp_pc || inst !== d || inst_valid !== 1'b1 || pc_plus4 !== ref_next(exp_pc, 1'b0, 32'h0) || misalign !== 1'b0) begin
                fails++;
                $display("FAIL random_%0d addr=%h exp %h inst=%h exp %h ok=%b pc4=%h mis=%b", i, a, exp_pc, inst, d, ok, pc_plus4, misalign);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] a;
        bit ok, leak;
        do_commit(1'b1, 32'h0000_0102);
        tests++; if (!ref_misaligned(ref_next(exp_pc, 1'b1, 32'h102)) || misalign !== 1'b1) begin fails++; $display("FAIL misalign_set got %b exp 1", misalign); end
        tests++; if (inst_valid !== 1'b0 || pc !== exp_pc) begin fails++; $display("FAIL halt_state got valid=%b pc=%h exp 0/%h", inst_valid, pc, exp_pc); end
        leak = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            commit = 1'b1; PCSel = 1'b0; imem_rsp_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (imem_req_valid || inst_valid || pc !== exp_pc || misalign !== 1'b1) leak = 1'b1;
        end
        commit = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        tests++; if (leak) begin fails++; $display("FAIL halt_frozen got activity exp none"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (pc !== RST_PC || misalign !== 1'b0) begin fails++; $display("FAIL halt_reset got pc=%h mis=%b exp %h/0", pc, misalign, RST_PC); end
        exp_pc = RST_PC;
        do_fetch(0, 1, 32'h0000_0013, a, ok);
        tests++; if (!ok || a !== RST_PC) begin fails++; $display("FAIL halt_resume got %h ok=%b exp %h", a, ok, RST_PC); end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit ok;
        do_commit(1'b1, 32'hFFFF_FFFC);
        exp_pc = ref_next(exp_pc, 1'b1, 32'hFFFF_FFFC);
        do_fetch(0, 1, 32'h0040_006F, a, ok);
        tests++; if (!ok || pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top_pc got %h exp fffffffc", pc); end
        tests++; if (pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_pc_plus4 got %h exp 00000000", pc_plus4); end
        do_commit(1'b0, 32'h1234_5678);
        exp_pc = ref_next(exp_pc, 1'b0, 32'h0);
        do_fetch(0, 1, 32'h0000_0013, a, ok);
        tests++; if (!ok || a !== 32'h0 || a !== exp_pc) begin fails++; $display("FAIL wrap_addr got %h exp 00000000", a); end
    endtask

    task automatic test_rst_in_wait();
        logic [31:0] a;
        bit ok;
        do_commit(1'b0, 32'h0);
        exp_pc = ref_next(exp_pc, 1'b0, 32'h0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        do_commit(1'b1, 32'h0000_0200);
        tests++; if (pc !== exp_pc || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL wait_commit_ignored got pc=%h req=%b val=%b exp pc=%h", pc, imem_req_valid, inst_valid, exp_pc); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (inst_valid !== 1'b0 || pc !== RST_PC || imem_req_valid !== 1'b0) begin fails++; $display("FAIL wait_reset got val=%b pc=%h req=%b exp 0/%h/0", inst_valid, pc, imem_req_valid, RST_PC); end
        @(negedge clk);
        tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin fails++; $display("FAIL wait_reset_refetch got req=%b addr=%h exp 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
        exp_pc = RST_PC;
        do_fetch(0, 3, 32'hCAFE_0093, a, ok);
        tests++; if (!ok || inst !== 32'hCAFE_0093 || a !== exp_pc) begin fails++; $display("FAIL wait_reset_fetch got %h ok=%b exp cafe0093", inst, ok); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_stall();
        test_jumps();
        test_rsp_ignored();
        test_random();
        test_misalign();
        test_wrap();
        test_rst_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
